// File: rtl/mac_result_fifo.sv
`default_nettype none
// ============================================================================
// mac_result_fifo : first-word-fall-through FIFO capturing MAC results; pushes
//                   into a full FIFO are dropped and flagged by sticky overflow.
// Optional macro MAC_FIFO_STATS_EN adds saturating push_cnt/drop_cnt outputs.
// Revision: 1.0
// ============================================================================
module mac_result_fifo #(
  parameter int  DATA_W = 32,
  parameter int  DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validi,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  input  logic              ready_i,
  output logic              valido,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow
`ifdef MAC_FIFO_STATS_EN
  ,
  output logic [15:0]       push_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int PTR_W = CNT_W - 1;

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("mac_result_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              pop, push, drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign valido   = ~empty;
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = ovf_q;

  // A pop frees the head slot this cycle, so a push into a full FIFO is still legal.
  assign pop  = valido & ready_i;
  assign push = validi & (~full | pop);
  assign drop = validi & ~push;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; empty masks it from data_out.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef MAC_FIFO_STATS_EN
  logic [15:0] push_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else if (clr) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push && (push_cnt_q != 16'hFFFF)) push_cnt_q <= push_cnt_q + 16'd1;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign push_cnt = push_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac_result_fifo.sv
`default_nettype none
// ============================================================================
// tb_mac_result_fifo : directed + randomized checks of mac_result_fifo against
//                      a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_mac_result_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              validi;
  logic [DATA_W-1:0] data_in;
  logic              clr;
  logic              ready_i;
  logic              valido;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
`ifdef MAC_FIFO_STATS_EN
  logic [15:0]       push_cnt;
  logic [15:0]       drop_cnt;
`endif

  mac_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .validi   (validi),
    .data_in  (data_in),
    .clr      (clr),
    .ready_i  (ready_i),
    .valido   (valido),
    .data_out (data_out),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
`ifdef MAC_FIFO_STATS_EN
    ,
    .push_cnt (push_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents in arrival order plus sticky flag and stats.
  logic [DATA_W-1:0] q[$];
  bit                m_ovf;
  int                m_push;
  int                m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_push = 0;
    m_drop = 0;
  endtask

  task automatic model_step();
    bit pop_now;
    bit room;
    if (clr) begin
      model_reset();
    end else begin
      pop_now = (q.size() != 0) && ready_i;
      room    = (q.size() < DEPTH) || pop_now;
      if (pop_now) void'(q.pop_front());
      if (validi) begin
        if (room) begin
          q.push_back(data_in);
          if (m_push < 65535) m_push++;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [DATA_W-1:0] head;
    head = (q.size() != 0) ? q[0] : '0;
    chk({tag, " valido"},   valido,   q.size() != 0);
    chk({tag, " data_out"}, data_out, head);
    chk({tag, " count"},    count,    q.size());
    chk({tag, " full"},     full,     q.size() == DEPTH);
    chk({tag, " empty"},    empty,    q.size() == 0);
    chk({tag, " overflow"}, overflow, m_ovf);
`ifdef MAC_FIFO_STATS_EN
    chk({tag, " push_cnt"}, push_cnt, m_push);
    chk({tag, " drop_cnt"}, drop_cnt, m_drop);
`endif
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r);
    validi  = v;
    data_in = d;
    ready_i = r;
  endtask

  initial begin
    int idx;
    int cyc;
    logic [DATA_W-1:0] exp_drain [4];

    rst = 1'b1; clr = 1'b0;
    drive(1'b0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;

    // Asynchronous reset with two entries held
    drive(1'b1, 32'h11, 1'b0); cycle("pre_rst1");
    drive(1'b1, 32'h22, 1'b0); cycle("pre_rst2");
    drive(1'b0, '0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    rst = 1'b0;
    cycle("post_rst");

    // Single pass-through, no same-cycle bypass
    drive(1'b1, 32'h7, 1'b1);
    #1;
    chk("no_bypass valido", valido, 1'b0);
    cycle("pass_push");
    chk("pass data", data_out, 32'h7);
    drive(1'b0, '0, 1'b1);
    cycle("pass_pop");
    chk("pass empty", empty, 1'b1);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, i, 1'b0);
      cycle($sformatf("fill%0d", i));
      if (i == 4) chk("fill full", full, 1'b1);
    end
    chk("fill overflow", overflow, 1'b1);
    drive(1'b0, '0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain_order%0d", i), data_out, i);
      cycle($sformatf("drain%0d", i));
    end
    chk("ovf_kept", overflow, 1'b1);

    // clr with simultaneous push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h21 + i, 1'b0);
      cycle($sformatf("preclr%0d", i));
    end
    clr = 1'b1;
    drive(1'b1, 32'd99, 1'b0);
    cycle("clr");
    clr = 1'b0;
    chk("clr count", count, 0);
    chk("clr overflow", overflow, 1'b0);
    drive(1'b0, '0, 1'b1);
    cycle("after_clr");
    chk("clr no99", data_out, 0);

    // Full with simultaneous pop
    for (int i = 10; i <= 13; i++) begin
      drive(1'b1, i, 1'b0);
      cycle($sformatf("fullpop_fill%0d", i));
    end
    drive(1'b1, 32'd14, 1'b1);
    cycle("fullpop_push");
    chk("fullpop count", count, 4);
    exp_drain = '{32'd11, 32'd12, 32'd13, 32'd14};
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fullpop_order%0d", i), data_out, exp_drain[i]);
      cycle("fullpop_drain");
    end
    chk("fullpop overflow", overflow, 1'b0);

    // Wrap-around: 9 words with random ready, never pushing into a blocked FIFO
    idx = 0;
    cyc = 0;
    while ((idx < 9 || q.size() != 0) && cyc < 200) begin
      ready_i = 1'($urandom_range(0, 1));
      if (idx < 9 && (q.size() < DEPTH || (ready_i && q.size() != 0))) begin
        validi  = 1'b1;
        data_in = 32'hA0 + idx;
        idx++;
      end else begin
        validi  = 1'b0;
        data_in = '0;
      end
      cycle("wrap");
      cyc++;
    end
    chk("wrap in_budget", cyc < 200, 1'b1);
    chk("wrap count", count, 0);
    chk("wrap overflow", overflow, 1'b0);

    // Randomized traffic including overflow and occasional clr
    for (int i = 0; i < 400; i++) begin
      validi  = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) == 0);
      clr     = ($urandom_range(0, 40) == 0);
      data_in = $urandom;
      cycle("rand");
    end
    clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
